cas_fsk_player: RTL and testbench

- Cassette playback transmitter. Converts a byte stream (CAS image bytes from SDRAM/ioctl loader) into the MSX 1200-baud FSK square wave.
- Output drives the core's cas_audio_in, which is read through PSG port A bit 7 and mixed to audio.
- BIOS software on the CPU decodes the waveform. This block is the transmitting end of that link.
- Playback advances only while the PPI cassette motor bit is asserted.

---
 rtl/cas_pkg.sv | 25 ++
 rtl/cas_fsk_player_if.sv | 24 ++
 rtl/cas_bit_gen.sv | 51 +++++
 rtl/cas_fsk_player.sv | 128 ++++++++++++
 tb/tb_cas_fsk_player.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cas_pkg.sv
// Shared types and defaults for the MSX cassette FSK player.
// 1200-baud MSX framing: start bit, 8 data bits LSB first, two stop bits.
package cas_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_DATA  = 2'b00,
        CMD_SHORT = 2'b01,
        CMD_LONG  = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    localparam int DEF_HALF_2400 = 746;
    localparam int DEF_LONG_HDR  = 16000;
    localparam int DEF_SHORT_HDR = 4000;
    localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/cas_fsk_player_if.sv
// Byte/command stream into the cassette player.
// Source holds data and hdr stable until the valid/ready handshake.
interface cas_fsk_player_if;

    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] s_hdr;

    modport master (
        output s_valid,
        output s_data,
        output s_hdr,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_hdr,
        output s_ready
    );

endinterface

// File: rtl/cas_bit_gen.sv
// One FSK bit: tick counter within a half-cycle, half-cycle index within a bit.
// A "0" is one 1200 Hz cycle, a "1" is two 2400 Hz cycles; both start high.
module cas_bit_gen #(
    parameter int HALF  = 746,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic adv,
    input  logic start,
    input  logic bit_val,
    output logic level,
    output logic cyc_done,
    output logic bit_done
);

    logic [CNT_W-1:0] tick_q, tick_d;
    logic [1:0]       half_q, half_d;
    logic             wrap;

    // Advance tick/half counters; start realigns to the top of a bit
    always_comb begin
        tick_d   = tick_q;
        half_d   = half_q;
        wrap     = adv && (tick_q == CNT_W'(HALF - 1));
        cyc_done = wrap && half_q[0];
        bit_done = wrap && (half_q == 2'd3);
        level    = bit_val ? ~half_q[0] : ~half_q[1];
        if (start) begin
            tick_d = '0;
            half_d = '0;
        end else if (wrap) begin
            tick_d = '0;
            half_d = half_q + 2'd1;
        end else if (adv) begin
            tick_d = tick_q + CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
            half_q <= '0;
        end else begin
            tick_q <= tick_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/cas_fsk_player.sv
// Cassette playback transmitter: bytes/headers in, MSX FSK square wave out.
// Everything but the input handshake is gated by clk_en and the motor bit.
module cas_fsk_player
    import cas_pkg::*;
#(
    parameter int HALF_2400 = DEF_HALF_2400,
    parameter int LONG_HDR  = DEF_LONG_HDR,
    parameter int SHORT_HDR = DEF_SHORT_HDR,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              motor,
    cas_fsk_player_if.slave   s,
    output logic              busy,
    output logic              cas_out
);

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             long_q, long_d;
    logic             ready_q, ready_d;

    logic             acc;
    logic             adv;
    logic             is_hdr;
    logic             bit_val;
    logic             level;
    logic             cyc_done;
    logic             bit_done;
    logic [CNT_W-1:0] hdr_last;
    cmd_t             cmd;

    assign s.s_ready = ready_q & motor;
    assign acc       = s.s_valid & s.s_ready;
    assign adv       = clk_en & motor;
    assign cmd       = cmd_t'(s.s_hdr);
    assign is_hdr    = (cmd == CMD_SHORT) || (cmd == CMD_LONG);
    assign hdr_last  = long_q ? CNT_W'(LONG_HDR - 1)
                              : CNT_W'(SHORT_HDR - 1);

    cas_bit_gen #(
        .HALF  (HALF_2400),
        .CNT_W (CNT_W)
    ) u_bit_gen (
        .clk      (clk),
        .reset    (reset),
        .adv      (adv),
        .start    (acc),
        .bit_val  (bit_val),
        .level    (level),
        .cyc_done (cyc_done),
        .bit_done (bit_done)
    );

    // Frame state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Frame sequencing: one start, eight data, two stop, or N header cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (acc) state_d = is_hdr ? HDR : START;
            START: if (bit_done) state_d = DATA;
            DATA:  if (bit_done && idx_q == 3'd7) state_d = STOP;
            STOP:  if (bit_done && idx_q[0]) state_d = IDLE;
            HDR:   if (cyc_done && cyc_q == hdr_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Current bit value and line level
    always_comb begin
        busy = (state_q != IDLE);
        case (state_q)
            DATA:      bit_val = shift_q[0];
            STOP, HDR: bit_val = 1'b1;
            default:   bit_val = 1'b0;
        endcase
        cas_out = busy & level;
    end

    // Shift register, bit index, header cycle count, ready
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        long_d  = long_q;
        ready_d = (state_q == IDLE) && !acc;
        if (acc) begin
            shift_d = s.s_data;
            idx_d   = '0;
            cyc_d   = '0;
            long_d  = (cmd == CMD_LONG);
        end else begin
            if (bit_done && (state_q == DATA || state_q == STOP))
                idx_d = idx_q + 3'd1;
            if (bit_done && state_q == DATA)
                shift_d = {1'b0, shift_q[7:1]};
            if (cyc_done && state_q == HDR)
                cyc_d = cyc_q + CNT_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
            long_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            long_q  <= long_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_cas_fsk_player.sv
// Directed bench for cas_fsk_player at HALF_2400=4 (16 ticks per bit).
// Captures cas_out per clk_en tick and compares against a waveform model.
module tb_cas_fsk_player;
    import cas_pkg::*;

    localparam int H  = 4;
    localparam int BT = 4 * H;
    localparam int FT = 11 * BT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clk_en = 1'b0;
    logic motor = 1'b0;
    logic busy;
    logic cas_out;

    cas_fsk_player_if bus ();

    cas_fsk_player #(
        .HALF_2400 (H),
        .LONG_HDR  (8),
        .SHORT_HDR (4),
        .CNT_W     (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .clk_en  (clk_en),
        .motor   (motor),
        .s       (bus),
        .busy    (busy),
        .cas_out (cas_out)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    logic lvl [0:511];
    int   n_ticks;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en);
        clk_en = en;
        @(posedge clk);
        #1;
    endtask

    // Record cas_out once per tick until busy falls or the budget runs out
    task automatic capture(input int k0, input int max);
        int k;
        k = k0;
        while (busy && k < max) begin
            lvl[k] = cas_out;
            step(1'b1);
            k++;
        end
        n_ticks = k;
    endtask

    function automatic logic exp_lvl(input logic b, input int t);
        int h;
        h = (t % BT) / H;
        return b ? (h % 2 == 0) : (h < 2);
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] d,
                               input int base);
        int bad;
        logic [10:0] fr;
        bad = -1;
        fr = {2'b11, d, 1'b0};
        for (int i = 0; i < FT; i++)
            if (bad < 0 && lvl[base + i] !== exp_lvl(fr[i / BT], i))
                bad = i;
        chk({tag, "_wave_first_bad_tick"}, bad, 32'hffff_ffff);
    endtask

    function automatic logic [10:0] decode(input int base);
        logic [10:0] dec;
        for (int i = 0; i < 11; i++)
            dec[i] = ~lvl[base + i * BT + H];
        return dec;
    endfunction

    task automatic offer(input string tag, input logic [1:0] hdr,
                         input logic [7:0] d);
        int w;
        w = 0;
        while (!bus.s_ready && w < 20) begin
            step(1'b0);
            w++;
        end
        chk({tag, "_ready"}, bus.s_ready, 1);
        bus.s_valid = 1'b1;
        bus.s_hdr   = hdr;
        bus.s_data  = d;
        step(1'b0);
        bus.s_valid = 1'b0;
        chk({tag, "_busy_on_accept"}, busy, 1);
        chk({tag, "_first_level"}, cas_out, 1);
    endtask

    task automatic tail(input string tag);
        chk({tag, "_cas_low_at_end"}, cas_out, 0);
        chk({tag, "_ready_low_same_clk"}, bus.s_ready, 0);
        step(1'b0);
        chk({tag, "_ready_next_clk"}, bus.s_ready, 1);
    endtask

    initial begin
        int bad;
        int chg;
        int rbad;
        logic hold;

        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_hdr   = 2'b00;

        // Reset state
        step(1'b0);
        chk("rst_cas_out", cas_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.s_ready, 0);
        motor = 1'b1;
        step(1'b0);
        chk("rst_ready_motor_on", bus.s_ready, 0);
        reset = 1'b0;
        step(1'b0);
        chk("ready_after_reset", bus.s_ready, 1);

        // Byte 0x00: nine "0" bits then two "1" bits
        offer("b00", 2'b00, 8'h00);
        capture(0, 400);
        chk("b00_ticks", n_ticks, FT);
        check_frame("b00", 8'h00, 0);
        chk("b00_decode", decode(0), 11'h600);
        tail("b00");

        // Byte 0xA5
        offer("bA5", 2'b00, 8'hA5);
        capture(0, 400);
        chk("bA5_ticks", n_ticks, FT);
        check_frame("bA5", 8'hA5, 0);
        chk("bA5_decode", decode(0), 11'h74A);
        tail("bA5");

        // Short header: 4 cycles of 2400 Hz, no start bit
        offer("hs", 2'b01, 8'hFF);
        capture(0, 400);
        chk("hs_ticks", n_ticks, 8 * H);
        bad = -1;
        for (int i = 0; i < 8 * H; i++)
            if (bad < 0 && lvl[i] !== logic'((i / H) % 2 == 0)) bad = i;
        chk("hs_wave_first_bad_tick", bad, 32'hffff_ffff);
        tail("hs");

        // Long header (8 cycles in this build)
        offer("hl", 2'b10, 8'h00);
        capture(0, 400);
        chk("hl_ticks", n_ticks, 16 * H);
        tail("hl");

        // Reserved command plays as a data byte
        offer("rsv", 2'b11, 8'h3C);
        capture(0, 400);
        chk("rsv_ticks", n_ticks, FT);
        check_frame("rsv", 8'h3C, 0);
        tail("rsv");

        // Motor pause mid-DATA for 100 clk_en ticks
        offer("mot", 2'b00, 8'hA5);
        for (int k = 0; k < 40; k++) begin
            lvl[k] = cas_out;
            step(1'b1);
        end
        motor = 1'b0;
        #1;
        chk("mot_ready_off", bus.s_ready, 0);
        hold = cas_out;
        chg  = 0;
        rbad = 0;
        for (int k = 0; k < 100; k++) begin
            step(1'b1);
            if (cas_out !== hold) chg++;
            if (bus.s_ready !== 1'b0) rbad++;
        end
        chk("mot_frozen_changes", chg, 0);
        chk("mot_ready_glitches", rbad, 0);
        chk("mot_busy_held", busy, 1);
        motor = 1'b1;
        capture(40, 400);
        chk("mot_ticks", n_ticks, FT);
        check_frame("mot", 8'hA5, 0);
        tail("mot");
        motor = 1'b0;
        #1;
        chk("idle_ready_motor_off", bus.s_ready, 0);
        motor = 1'b1;
        #1;
        chk("idle_ready_motor_on", bus.s_ready, 1);

        // Asynchronous reset during data bit 3
        offer("rm", 2'b00, 8'h08);
        for (int k = 0; k < 66; k++) step(1'b1);
        chk("rm_level_before", cas_out, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rm_cas_out", cas_out, 0);
        chk("rm_busy", busy, 0);
        chk("rm_ready", bus.s_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0);
        chk("rm_ready_after", bus.s_ready, 1);
        offer("rm2", 2'b00, 8'h00);
        capture(0, 400);
        chk("rm2_ticks", n_ticks, FT);
        check_frame("rm2", 8'h00, 0);
        tail("rm2");

        // Two bytes back to back with s_valid held
        bus.s_valid = 1'b1;
        bus.s_hdr   = 2'b00;
        bus.s_data  = 8'h5A;
        step(1'b0);
        bus.s_data  = 8'hC3;
        chk("bb_busy1", busy, 1);
        capture(0, 400);
        chk("bb_ticks1", n_ticks, FT);
        check_frame("bb1", 8'h5A, 0);
        chk("bb_ready_at_fall", bus.s_ready, 0);
        step(1'b0);
        chk("bb_ready_next", bus.s_ready, 1);
        chk("bb_gap_idle", busy, 0);
        step(1'b0);
        bus.s_valid = 1'b0;
        chk("bb_busy2", busy, 1);
        chk("bb_first_level2", cas_out, 1);
        capture(FT, 500);
        chk("bb_ticks_total", n_ticks, 2 * FT);
        check_frame("bb2", 8'hC3, FT);
        tail("bb2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
